board_ctrl: RTL
===============

Name: board_ctrl

Overview:
Parametrised board-support block for the FPGA top level. It is the generalised successor of the fixed heartbeat counter and raw button/LED wiring.
- Generates a stretched, synchronised SoC reset.
- Debounces NUM_BTN buttons and records rising-edge events.
- Drives NUM_LED LEDs in per-channel modes (off, on, heartbeat, programmable blink).
- Exposes a small register interface on the SoC peripheral bus.

Parameters:
NUM_BTN, 7, number of button inputs (1..32)
NUM_LED, 8, number of LED outputs (1..16)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button change (10 ms at 25 MHz)
RST_HOLD_CYCLES, 1024, cycles soc_rst_no is held low after reset_n release or a watchdog bite
HB_BITS, 23, heartbeat counter width; heartbeat LED = counter MSB
LED_MODE_RST, 16'h0002, reset value of the LED_MODE register (LED0 = heartbeat)
WDT_CYCLES, 33554432, watchdog timeout in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn_i  input  NUM_BTN  raw asynchronous button levels, active-high
soc_rst_no  output  1  SoC reset, active-low, deasserted synchronously
btn_o  output  NUM_BTN  debounced button levels
led_o  output  NUM_LED  LED drive, active-high
reg_en_i  input  1  register access strobe
reg_we_i  input  1  1 = write, 0 = read
reg_addr_i  input  3  word address
reg_wdata_i  input  32  write data
reg_rdata_o  output  32  read data, registered

Behaviour:
- Reset: reset_n is asynchronous active-low; clock is clk. While reset_n is low, all of the following hold:
  - soc_rst_no = 0, btn_o = 0, led_o = 0, reg_rdata_o = 0.
  - All counters are 0; BTN_EVENT = 0; BLINK_DIV = 24'd12499999.
  - LED_MODE = LED_MODE_RST.
- Reset release: reset_n deassertion passes through a 2-FF synchroniser. A hold counter then runs. soc_rst_no rises exactly RST_HOLD_CYCLES cycles after the synchronised release. If reset_n is reasserted mid-hold, the hold restarts from 0.
- Button path:
  - Each btn_i bit passes through a 2-FF synchroniser.
  - A per-channel counter increments while the synced bit differs from btn_o, and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_o updates on the next edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach btn_o.
  - Latency from a clean edge on btn_i to btn_o is DEBOUNCE_CYCLES+2 cycles.
- Button events: a 0->1 transition on btn_o[i] sets BTN_EVENT[i] (sticky).
- Heartbeat: a free-running HB_BITS counter that wraps; its MSB is the heartbeat source.
- Blink: a 24-bit down-counter.
  - At 0 it reloads from BLINK_DIV and toggles the blink phase.
  - BLINK_DIV = 0 toggles the phase every cycle.
  - Writing BLINK_DIV also loads the down-counter immediately.
- LED mode: LED_MODE holds 2 bits per LED. For LED i the field is bits [2i+1:2i]:
  - 00 = off
  - 01 = on
  - 10 = heartbeat MSB
  - 11 = blink phase
  - led_o is registered: one cycle from the source to the pin.
- Register map (word address):
  - 0 LED_MODE, RW; bits above 2*NUM_LED read 0.
  - 1 BTN_STATE, RO, = btn_o.
  - 2 BTN_EVENT, write-1-to-clear. If a set and a clear hit the same bit in the same cycle, the set wins.
  - 3 BLINK_DIV, RW, 24 bits; upper bits read 0.
  - 4 WDT, see the optional feature.
  - 5..7 read 0; writes are ignored.
- Register timing:
  - Read: reg_en_i=1 with reg_we_i=0 at edge N; reg_rdata_o is valid after edge N and holds until the next read.
  - Write: takes effect at the edge where reg_en_i=1 and reg_we_i=1.
  - There is no stall and no error response.

Optional Feature:
BOARD_CTRL_WDT_EN
- Defined: register 4 is the watchdog register.
  - bit0 = enable (RW, resets to 0).
  - Writing with bit1=1 is a kick; it clears the watchdog counter. bit1 reads 0.
  - bit31 = WDT_CAUSE, RO, sticky; cleared only by reset_n.
  - While enabled, the counter increments every cycle.
  - On reaching WDT_CYCLES-1 (a bite): the counter clears, WDT_CAUSE is set, and soc_rst_no goes low for RST_HOLD_CYCLES cycles.
  - The block's own registers are not reset by a bite.
  - The counter does not run while soc_rst_no is low.
- Undefined: no watchdog logic; register 4 reads 0, writes are ignored, and soc_rst_no depends only on reset_n.

Test Plan:
- Reset stretch: assert reset_n low for 5 cycles, release -> soc_rst_no = 0 for 2+1024 cycles, then 1. Pulse reset_n low at hold cycle 500 -> the hold restarts and soc_rst_no stays 0.
- Debounce (DEBOUNCE_CYCLES=16): btn_i[3] glitches high for 10 cycles -> btn_o[3] stays 0. Hold btn_i[3] high -> btn_o[3]=1 exactly 18 cycles after the edge, and BTN_EVENT reads 0x08.
- Event W1C collision: BTN_EVENT[3]=1; write 0x08 in the same cycle btn_o[1] rises -> the next read returns 0x02.
- LED modes: write LED_MODE=0x00F1 and BLINK_DIV=3 -> led_o[0]=1, led_o[1]=0, led_o[3:2] toggle every 4 cycles in phase. Read LED_MODE -> 0x000000F1.
- Register map: read address 6 -> 0. Write BLINK_DIV=0xFFFFFFFF, read back -> 0x00FFFFFF.
- Watchdog (BOARD_CTRL_WDT_EN, WDT_CYCLES=64): write WDT=1, no kick -> 64 cycles later soc_rst_no low for 1024 cycles and WDT reads 0x80000001. Kick every 50 cycles -> no bite.

Source files
------------

// File: rtl/board_ctrl.sv
// board_ctrl: SoC reset stretcher, button debouncer with sticky events, LED mode driver
// and register block. Define BOARD_CTRL_WDT_EN to add the watchdog at register 4.
module board_ctrl #(
   parameter int          NUM_BTN         = 7,
   parameter int          NUM_LED         = 8,
   parameter int          DEBOUNCE_CYCLES = 250000,
   parameter int          RST_HOLD_CYCLES = 1024,
   parameter int          HB_BITS         = 23,
   parameter logic [31:0] LED_MODE_RST    = 32'h0000_0002,
   parameter int          WDT_CYCLES      = 33554432
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] btn_i,
   output logic               soc_rst_no,
   output logic [NUM_BTN-1:0] btn_o,
   output logic [NUM_LED-1:0] led_o,
   input  logic               reg_en_i,
   input  logic               reg_we_i,
   input  logic [2:0]         reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic [31:0]        reg_rdata_o
);
   localparam int              DB_W          = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int              HOLD_W        = $clog2(RST_HOLD_CYCLES + 1);
   localparam int              MODE_W        = 2 * NUM_LED;
   localparam logic [DB_W-1:0]   DB_LAST       = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST     = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [23:0]       BLINK_DIV_RST = 24'd12499999;

   if (NUM_BTN < 1 || NUM_BTN > 32 || NUM_LED < 1 || NUM_LED > 16 || DEBOUNCE_CYCLES < 1 ||
       RST_HOLD_CYCLES < 1 || HB_BITS < 1 || WDT_CYCLES < 2) begin : g_bad_params
      $error("board_ctrl: parameter out of range");
   end

   logic wr, rd;
   logic wr_led_mode, wr_btn_event, wr_blink_div;
   assign wr           = reg_en_i & reg_we_i;
   assign rd           = reg_en_i & ~reg_we_i;
   assign wr_led_mode  = wr && (reg_addr_i == 3'd0);
   assign wr_btn_event = wr && (reg_addr_i == 3'd2);
   assign wr_blink_div = wr && (reg_addr_i == 3'd3);

   // Every write-data bit feeds some register in at least one configuration.
   logic unused_wdata;
   assign unused_wdata = ^reg_wdata_i;

   logic        bite;
   logic [31:0] wdt_rdata;

   // ---------------- SoC reset stretcher ----------------
   logic [1:0]        rst_sync;
   logic [HOLD_W-1:0] hold_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync   <= '0;
         hold_cnt   <= '0;
         soc_rst_no <= 1'b0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
         if (soc_rst_no) begin
            if (bite) begin
               soc_rst_no <= 1'b0;
               hold_cnt   <= '0;
            end
         end else if (rst_sync[1]) begin
            if (hold_cnt == HOLD_LAST) begin
               soc_rst_no <= 1'b1;
               hold_cnt   <= '0;
            end else begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end
         end
      end
   end

   // ---------------- Button debounce ----------------
   logic [NUM_BTN-1:0] btn_rise;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [1:0]      sync;
      logic [DB_W-1:0] cnt;
      logic            state_reg;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync      <= '0;
            cnt       <= '0;
            state_reg <= 1'b0;
         end else begin
            sync <= {sync[0], btn_i[gi]};
            if (sync[1] == state_reg) begin
               cnt <= '0;
            end else if (cnt == DB_LAST) begin
               state_reg <= sync[1];
               cnt       <= '0;
            end else begin
               cnt <= cnt + DB_W'(1);
            end
         end
      end

      assign btn_o[gi]    = state_reg;
      assign btn_rise[gi] = sync[1] & ~state_reg & (cnt == DB_LAST);
   end

   // Set wins over a simultaneous write-1-to-clear.
   logic [NUM_BTN-1:0] btn_event;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_event <= '0;
      end else if (wr_btn_event) begin
         btn_event <= (btn_event & ~reg_wdata_i[NUM_BTN-1:0]) | btn_rise;
      end else begin
         btn_event <= btn_event | btn_rise;
      end
   end

   // ---------------- Heartbeat and blink ----------------
   logic [HB_BITS-1:0] hb_cnt;
   logic [23:0]        blink_div;
   logic [23:0]        blink_cnt;
   logic               blink_phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hb_cnt      <= '0;
         blink_div   <= BLINK_DIV_RST;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         hb_cnt <= hb_cnt + HB_BITS'(1);
         if (wr_blink_div) begin
            blink_div <= reg_wdata_i[23:0];
            blink_cnt <= reg_wdata_i[23:0];
         end else if (blink_cnt == 24'd0) begin
            blink_cnt   <= blink_div;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt - 24'd1;
         end
      end
   end

   // ---------------- LED drive ----------------
   logic [MODE_W-1:0]  led_mode;
   logic [NUM_LED-1:0] led_next;

   for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_led
      logic [1:0] sel;
      assign sel          = led_mode[2*gi +: 2];
      assign led_next[gi] = (sel == 2'b00) ? 1'b0 :
                            (sel == 2'b01) ? 1'b1 :
                            (sel == 2'b10) ? hb_cnt[HB_BITS-1] : blink_phase;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_mode <= LED_MODE_RST[MODE_W-1:0];
         led_o    <= '0;
      end else begin
         if (wr_led_mode) begin
            led_mode <= reg_wdata_i[MODE_W-1:0];
         end
         led_o <= led_next;
      end
   end

   // ---------------- Watchdog ----------------
`ifdef BOARD_CTRL_WDT_EN
   localparam int             WDT_W    = $clog2(WDT_CYCLES + 1);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic             wr_wdt, kick;
   logic             wdt_en, wdt_cause;
   logic [WDT_W-1:0] wdt_cnt;

   assign wr_wdt    = wr && (reg_addr_i == 3'd4);
   assign kick      = wr_wdt & reg_wdata_i[1];
   // The counter is frozen while the SoC is held in reset, so it cannot bite again then.
   assign bite      = wdt_en & soc_rst_no & ~kick & (wdt_cnt == WDT_LAST);
   assign wdt_rdata = {wdt_cause, 30'd0, wdt_en};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdt_en    <= 1'b0;
         wdt_cause <= 1'b0;
         wdt_cnt   <= '0;
      end else begin
         if (wr_wdt) begin
            wdt_en <= reg_wdata_i[0];
         end
         if (kick || bite) begin
            wdt_cnt <= '0;
         end else if (wdt_en && soc_rst_no) begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
         end
         if (bite) begin
            wdt_cause <= 1'b1;
         end
      end
   end
`else
   assign bite      = 1'b0;
   assign wdt_rdata = '0;
`endif

   // ---------------- Register read ----------------
   logic [31:0] rdata_next;

   always_comb begin
      rdata_next = '0;
      case (reg_addr_i)
         3'd0:    rdata_next = 32'(led_mode);
         3'd1:    rdata_next = 32'(btn_o);
         3'd2:    rdata_next = 32'(btn_event);
         3'd3:    rdata_next = {8'd0, blink_div};
         3'd4:    rdata_next = wdt_rdata;
         default: rdata_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_rdata_o <= '0;
      end else if (rd) begin
         reg_rdata_o <= rdata_next;
      end
   end

endmodule
